psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter NUM_PE, default 4, number of PE psum buffers arbitrated (2..16).
REQ-002 Parameter DATA_WIDTH, default 32, psum word width (matches PE adder width).
REQ-003 Parameter CNT_WIDTH, default 10, width of transfer-count configuration and counters.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rstn  input  1  asynchronous active-low reset.
REQ-006 Port en  input  1  global enable; low freezes all state.
REQ-007 Port start  input  1  one-cycle pulse; begins a collection pass.
REQ-008 Port cfg_total  input  CNT_WIDTH  number of psums to collect in the pass; sampled on accepted start.
REQ-009 Port pe_empty  input  NUM_PE  per-PE psum buffer empty flag.
REQ-010 Port pe_dout  input  NUM_PE*DATA_WIDTH  per-PE head-of-buffer word; PE i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; valid combinationally while pe_empty[i]=0.
REQ-011 Port pe_ren  output  NUM_PE  per-PE pop strobe; at most one bit high per cycle.
REQ-012 Port out_valid  output  1  output register holds a word.
REQ-013 Port out_ready  input  1  downstream accepts word when out_valid and out_ready high at clock edge.
REQ-014 Port out_data  output  DATA_WIDTH  collected psum.
REQ-015 Port out_pe_id  output  $clog2(NUM_PE)  index of source PE of out_data.
REQ-016 Port busy  output  1  high in RUN state.
REQ-017 Port done  output  1  one-cycle pulse at pass completion.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on start&en; RUN->DONE when accept counter equals latched total; DONE->IDLE unconditionally next enabled cycle; done high only in DONE.
REQ-019 start outside IDLE shall be ignored; start with cfg_total=0 shall go RUN then DONE with no pe_ren asserted.
REQ-020 Entering RUN shall clear pop counter and accept counter and latch cfg_total.
REQ-021 Grant eligible only when: state RUN, en high, pop counter < latched total, and output register free (out_valid=0 or out_valid&out_ready this cycle).
REQ-022 Arbitration shall be round-robin: search pe_empty from priority pointer upward with wrap, grant first PE with pe_empty=0; pe_ren of grantee is combinational in the same cycle.
REQ-023 On grant, next edge: out_data<=pe_dout of grantee, out_pe_id<=grantee index, out_valid<=1, pop counter +1, pointer<=grantee+1 mod NUM_PE.
REQ-024 Without grant, pointer shall hold; out_valid shall clear after an accept with no new grant.
REQ-025 Simultaneous accept and grant in one cycle shall sustain one word per cycle with no bubble.
REQ-026 Latency: pe_empty[i] falling with free output register -> out_valid high at next edge (1 cycle).
REQ-027 out_data/out_pe_id shall stay stable while out_valid=1 and out_ready=0.
REQ-028 Accept counter increments on each out_valid&out_ready&en edge; counters saturate never (total bounds them).
REQ-029 en low: no pe_ren, no counter/pointer/FSM/output change, accepts not counted; out_valid held.
REQ-030 All PEs empty during RUN: pe_ren=0, FSM stays RUN indefinitely.

Reset
REQ-031 rstn low asynchronously: state IDLE, pointer 0, counters 0, out_valid 0, out_data 0, out_pe_id 0, done 0, busy 0, pe_ren 0.
REQ-032 Reset mid-pass shall discard any held output word; no pe_ren until new start.

Verification
REQ-033 NUM_PE=4, all PEs non-empty, cfg_total=8, out_ready=1 -> grants PE0,1,2,3,0,1,2,3 on consecutive cycles, 8 outputs back-to-back, done pulse one cycle after 8th accept.
REQ-034 Only PE2 non-empty (3 words), cfg_total=3 -> out_pe_id=2 three times, pe_ren[2] exactly 3 cycles, no other pe_ren.
REQ-035 out_ready held low 5 cycles after first word -> out_data/out_pe_id stable, pe_ren all 0 for those cycles, resume on out_ready=1.
REQ-036 cfg_total=2 with all PEs holding 4 words -> exactly 2 pops total, then DONE, IDLE; further pe_empty=0 causes no pe_ren.
REQ-037 en low 3 cycles mid-pass then high -> zero state change during freeze; sequence continues identically to unfrozen run.
REQ-038 rstn asserted with out_valid=1 mid-pass -> out_valid 0 immediately, IDLE; start with cfg_total=1 afterwards grants from PE0.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: round-robin collector that drains per-PE psum buffers into
// one registered output stream, counting a configured number of words per pass.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A word
// transfers on a rising edge where out_valid, out_ready and en are all high.
// Once out_valid is raised, out_data/out_pe_id hold until that transfer.
// On the PE side, pe_ren[i] pops the head word of PE i at the same edge.
module psum_collector #(
    parameter int NUM_PE     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 10,
    parameter int ID_W       = $clog2(NUM_PE)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         cfg_total,
    input  logic [NUM_PE-1:0]            pe_empty,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_dout,
    output logic [NUM_PE-1:0]            pe_ren,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ID_W-1:0]              out_pe_id,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ID_W-1:0]       ptr;
    logic [CNT_WIDTH-1:0]  pop_cnt;
    logic [CNT_WIDTH-1:0]  acc_cnt;
    logic [CNT_WIDTH-1:0]  total;

    logic                  start_go;
    logic                  accept;
    logic                  eligible;
    logic                  found;
    logic                  grant;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand;
    logic [ID_W:0]         sum;
    logic [DATA_WIDTH-1:0] pe_word [NUM_PE];

    // Split the flat PE data bus into one word per PE.
    for (genvar g = 0; g < NUM_PE; g++) begin : g_unpack
        assign pe_word[g] = pe_dout[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign start_go  = en && start && (state == IDLE);
    assign accept    = en && out_valid && out_ready;
    // A new word may be loaded when the output register is empty or is being
    // drained this very cycle, which keeps a full-rate stream bubble-free.
    assign eligible  = en && (state == RUN) && (pop_cnt < total) &&
                       (!out_valid || out_ready);
    assign grant     = eligible && found;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // Round-robin search: first non-empty PE at or above the pointer, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_PE)) begin
                sum = sum - (ID_W+1)'(NUM_PE);
            end
            cand = sum[ID_W-1:0];
            if (!found && !pe_empty[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pop strobe goes to the grantee in the same cycle as the grant.
    always_comb begin
        pe_ren = '0;
        if (grant) begin
            pe_ren[grant_idx] = 1'b1;
        end
    end

    // State register; en low freezes the FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    // Next-state logic; a pass ends once every counted word has been accepted.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (acc_cnt == total) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counters, pointer and output register; all held while en is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            pop_cnt   <= '0;
            acc_cnt   <= '0;
            total     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pe_id <= '0;
        end else if (en) begin
            if (start_go) begin
                pop_cnt <= '0;
                acc_cnt <= '0;
                total   <= cfg_total;
            end else begin
                if (grant) begin
                    pop_cnt <= pop_cnt + CNT_WIDTH'(1);
                end
                if (accept) begin
                    acc_cnt <= acc_cnt + CNT_WIDTH'(1);
                end
            end
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= pe_word[grant_idx];
                out_pe_id <= grant_idx;
                ptr       <= (grant_idx == ID_W'(NUM_PE - 1)) ? '0 : grant_idx + ID_W'(1);
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: PE buffer model, table of collection passes,
// hand-written backpressure / freeze / reset / starvation sequences.
module tb_psum_collector;

    localparam int NUM_PE = 4;
    localparam int DW     = 32;
    localparam int CW     = 10;
    localparam int IW     = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic              start;
    logic [CW-1:0]     cfg_total;
    logic [NUM_PE-1:0] pe_empty;
    logic [NUM_PE*DW-1:0] pe_dout;
    logic [NUM_PE-1:0] pe_ren;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_pe_id;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    psum_collector #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .start(start), .cfg_total(cfg_total),
        .pe_empty(pe_empty), .pe_dout(pe_dout), .pe_ren(pe_ren),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pe_id(out_pe_id), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [IW+DW-1:0] exp_q[$];
    int pe_left [NUM_PE];
    int pe_head [NUM_PE];
    int occ     [NUM_PE];
    int tick_no, done_tick, done_cnt, busy_cnt, ren_tot;
    bit saw_done;

    typedef struct packed {
        logic [7:0]       total;
        logic [3:0][3:0]  cnt;
        logic [7:0][1:0]  ids;
        logic [7:0]       done_at;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [DW-1:0] word(input int p, input int n);
        return 32'hC000_0000 | (32'(p) << 16) | 32'(n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // PE buffer model drives empty flags and head words.
    task automatic drive_pe();
        for (int i = 0; i < NUM_PE; i++) begin
            pe_empty[i] = (pe_left[i] == 0);
            pe_dout[i*DW +: DW] = word(i, pe_head[i]);
        end
    endtask

    task automatic load_pe(input int c0, input int c1, input int c2, input int c3);
        pe_left[0] = c0; pe_left[1] = c1; pe_left[2] = c2; pe_left[3] = c3;
        for (int i = 0; i < NUM_PE; i++) begin
            pe_head[i] = 0;
            occ[i]     = 0;
        end
        drive_pe();
    endtask

    task automatic expect_word(input int p);
        exp_q.push_back({IW'(p), word(p, occ[p])});
        occ[p]++;
    endtask

    task automatic begin_pass();
        tick_no = 0; saw_done = 0; done_tick = -1;
        done_cnt = 0; busy_cnt = 0; ren_tot = 0;
    endtask

    // One clock: sample mid-cycle, score, cross the edge, update PE model.
    task automatic tick();
        logic [NUM_PE-1:0] pops;
        logic [IW+DW-1:0]  e;
        #1;
        check("ren_onehot", 64'($onehot0(pe_ren)), 64'd1);
        pops = pe_ren;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_ren[i]) begin
                ren_tot++;
                if (pe_left[i] == 0) check("ren_on_empty", 64'(i), 64'hFF);
            end
        end
        if (rstn && en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out actual=%0h required=none", {out_pe_id, out_data});
            end else begin
                e = exp_q.pop_front();
                check("out_word", 64'({out_pe_id, out_data}), 64'(e));
            end
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (!saw_done) done_tick = tick_no;
            saw_done = 1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pops[i] && pe_left[i] > 0) begin
                pe_left[i]--;
                pe_head[i]++;
            end
        end
        drive_pe();
        tick_no++;
    endtask

    task automatic run_pass(input int total, input int budget);
        start = 1'b1;
        cfg_total = CW'(total);
        tick();
        start = 1'b0;
        while (!saw_done && tick_no < budget) tick();
        check("done_seen", 64'(saw_done), 64'd1);
    endtask

    task automatic end_pass(input int total, input int exp_done);
        check("done_tick", 64'(done_tick), 64'(exp_done));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done - 1));
        check("pops", 64'(ren_tot), 64'(total));
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) tick();
        check("pops_after_done", 64'(ren_tot), 64'(total));
        check("idle_after", 64'({busy, done, state_dbg}), 64'd0);
    endtask

    initial begin
        tbl[0] = '{total: 8'd8, cnt: {4'd2, 4'd2, 4'd2, 4'd2},
                   ids: {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, done_at: 8'd11};
        tbl[1] = '{total: 8'd3, cnt: {4'd0, 4'd3, 4'd0, 4'd0},
                   ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2}, done_at: 8'd6};
        tbl[2] = '{total: 8'd2, cnt: {4'd4, 4'd4, 4'd4, 4'd4},
                   ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3}, done_at: 8'd5};
        tbl[3] = '{total: 8'd0, cnt: {4'd1, 4'd1, 4'd1, 4'd1},
                   ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, done_at: 8'd2};
        tbl[4] = '{total: 8'd3, cnt: {4'd0, 4'd2, 4'd0, 4'd1},
                   ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2}, done_at: 8'd6};

        // Reset
        rstn = 1'b0; en = 1'b1; start = 1'b0; cfg_total = '0; out_ready = 1'b1;
        load_pe(1, 1, 1, 1);
        #1;
        check("rst_outputs", 64'({pe_ren, out_valid, out_data, out_pe_id, busy, done, state_dbg}), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Table of passes (pointer carries over from pass to pass)
        for (int t = 0; t < 5; t++) begin
            load_pe(int'(tbl[t].cnt[0]), int'(tbl[t].cnt[1]), int'(tbl[t].cnt[2]), int'(tbl[t].cnt[3]));
            for (int k = 0; k < int'(tbl[t].total); k++) expect_word(int'(tbl[t].ids[k]));
            begin_pass();
            run_pass(int'(tbl[t].total), 40);
            end_pass(int'(tbl[t].total), int'(tbl[t].done_at));
        end

        // Backpressure: first word (PE3) held 5 cycles; a stray start is ignored
        load_pe(2, 2, 2, 2);
        expect_word(3); expect_word(0); expect_word(1); expect_word(2);
        begin_pass();
        start = 1'b1; cfg_total = CW'(4); tick(); start = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            cfg_total = CW'(1);
            #1;
            check("stall_ren", 64'(pe_ren), 64'd0);
            check("stall_word", 64'({out_valid, out_pe_id, out_data}), 64'({1'b1, 2'd3, word(3, 0)}));
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        while (!saw_done && tick_no < 40) tick();
        check("done_seen", 64'(saw_done), 64'd1);
        end_pass(4, 12);

        // Enable freeze for 3 cycles with a PE0 word held
        load_pe(2, 2, 2, 2);
        expect_word(3); expect_word(0); expect_word(1); expect_word(2);
        begin_pass();
        start = 1'b1; cfg_total = CW'(4); tick(); start = 1'b0;
        tick(); tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("frz_ren", 64'(pe_ren), 64'd0);
            check("frz_state", 64'({out_valid, busy, done, out_pe_id, out_data}),
                  64'({1'b1, 1'b1, 1'b0, 2'd0, word(0, 0)}));
            tick();
        end
        en = 1'b1;
        while (!saw_done && tick_no < 40) tick();
        check("done_seen", 64'(saw_done), 64'd1);
        end_pass(4, 10);

        // Reset mid-pass with a held word, then restart from PE0
        load_pe(2, 2, 2, 2);
        expect_word(3);
        begin_pass();
        start = 1'b1; cfg_total = CW'(4); tick(); start = 1'b0;
        tick();
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_outputs", 64'({pe_ren, out_valid, out_data, out_pe_id, busy, done, state_dbg}), 64'd0);
        exp_q.delete();
        tick(); tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("postrst_idle", 64'({pe_ren, busy, out_valid}), 64'd0);
            tick();
        end
        load_pe(2, 2, 2, 2);
        expect_word(0);
        begin_pass();
        run_pass(1, 20);
        end_pass(1, 4);

        // Starved pass: all empty for 10 cycles, then PE1 fills
        load_pe(0, 0, 0, 0);
        begin_pass();
        start = 1'b1; cfg_total = CW'(2); tick(); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve", 64'({pe_ren, busy, done, out_valid}), 64'({4'b0000, 1'b1, 1'b0, 1'b0}));
            tick();
        end
        load_pe(0, 2, 0, 0);
        expect_word(1); expect_word(1);
        #1;
        check("fill_ren", 64'(pe_ren), 64'b0010);
        tick();
        #1;
        check("fill_latency", 64'(out_valid), 64'd1);
        while (!saw_done && tick_no < 40) tick();
        check("done_seen", 64'(saw_done), 64'd1);
        end_pass(2, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
